// File: rtl/midi_pkg.sv
// midi_pkg: shared types and helpers for the MIDI channel-voice transmitter.
//   - ST_* : status-byte high nibbles for the seven channel-voice messages
//   - midi_state_t : serializer FSM states
//   - midi_evt_t : queued event {type, channel, d1[6:0], d2[6:0]}
//   - msg_len() : number of data bytes for a message type
//   - status_byte() : status byte {1, type, channel} for a queued event
package midi_pkg;

  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [3:0] ST_POLY_AT  = 4'hA;
  localparam logic [3:0] ST_CTRL     = 4'hB;
  localparam logic [3:0] ST_PRG_CH   = 4'hC;
  localparam logic [3:0] ST_CH_PRES  = 4'hD;
  localparam logic [3:0] ST_PITCH    = 4'hE;

  typedef enum logic [2:0] {IDLE, LOAD, STAT, D1, D2} midi_state_t;

  typedef struct packed {
    logic [2:0] typ;
    logic [3:0] ch;
    logic [6:0] d1;
    logic [6:0] d2;
  } midi_evt_t;

  localparam int unsigned EVT_W = $bits(midi_evt_t);

  function automatic logic [1:0] msg_len(input logic [2:0] typ);
    logic [3:0] nib;
    logic [1:0] len;
    nib = {1'b1, typ};
    case (nib)
      ST_PRG_CH, ST_CH_PRES:                                len = 2'd1;
      ST_NOTE_OFF, ST_NOTE_ON, ST_POLY_AT, ST_CTRL, ST_PITCH: len = 2'd2;
      default:                                              len = 2'd2;
    endcase
    return len;
  endfunction

  function automatic logic [7:0] status_byte(input midi_evt_t e);
    return {1'b1, e.typ, e.ch};
  endfunction

endpackage

// File: rtl/midi_evt_fifo.sv
// midi_evt_fifo: synchronous event queue with registered level/full/empty.
// Ports:
//   CLOCK_50, reset_reg_N : clock, asynchronous active-low reset
//   push_i, wdata_i       : write request and data (ignored while full)
//   pop_i, rdata_o        : read request (ignored while empty); rdata_o shows the head
//   level_o               : number of stored entries (0..FIFO_DEPTH)
//   full_o, empty_o       : registered status flags
module midi_evt_fifo
  import midi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FIFO_AW    = 2,
  parameter int unsigned DATA_W     = EVT_W
) (
  input  logic              CLOCK_50,
  input  logic              reset_reg_N,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [FIFO_AW:0]  level_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               full_q, empty_q;
  logic               push_ok, pop_ok;

  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_q;

  always_comb begin
    level_d = level_q;
    if (push_ok && !pop_ok) begin
      level_d = level_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      level_d = level_q - 1'b1;
    end
  end

  // Storage needs no reset; only pointers and flags define the contents.
  always_ff @(posedge CLOCK_50) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Power-of-two depth: pointers wrap naturally.
  always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      full_q  <= (level_d == (FIFO_AW+1)'(FIFO_DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/midi_msg_tx.sv
// midi_msg_tx: queues channel-voice MIDI events and serializes each one into
// status and data bytes for the MIDI UART transmitter.
// Ports:
//   CLOCK_50, reset_reg_N        : clock, asynchronous active-low reset
//   ev_valid/ev_ready            : event handshake (ev_ready = queue not full)
//   ev_type, ev_ch, ev_d1, ev_d2 : event fields (type 7 is illegal and dropped)
//   midi_out_ready               : UART can take a byte
//   midi_send_byte/midi_out_data : one-cycle byte strobe and its data
//   ev_err                       : one-cycle pulse after a type-7 offer
//   busy                         : serializer active or queue non-empty
//   fifo_level                   : queued event count
// Build option: define MIDI_RUNNING_STATUS_EN to omit a status byte that
// repeats the previously transmitted one.
module midi_msg_tx
  import midi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FIFO_AW    = 2,
  parameter int unsigned GUARD_CYC  = 2
) (
  input  logic             CLOCK_50,
  input  logic             reset_reg_N,
  input  logic             ev_valid,
  output logic             ev_ready,
  input  logic [2:0]       ev_type,
  input  logic [3:0]       ev_ch,
  input  logic [7:0]       ev_d1,
  input  logic [7:0]       ev_d2,
  input  logic             midi_out_ready,
  output logic             midi_send_byte,
  output logic [7:0]       midi_out_data,
  output logic             ev_err,
  output logic             busy,
  output logic [FIFO_AW:0] fifo_level
);

  localparam int unsigned GW = $clog2(GUARD_CYC + 1);

  midi_state_t state_q;
  midi_evt_t   cur_q;
  midi_evt_t   fifo_wdata, fifo_rdata;
  logic [GW-1:0] guard_q;
  logic        send_q, err_q, busy_q;
  logic [7:0]  data_q;
  logic        fifo_full, fifo_empty;
  logic        push_en, pop_en, fire, next_idle, busy_d;
  logic        unused_data_msb;
`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0]  last_status_q;
`endif

  // Data bytes always go out with bit 7 clear.
  assign unused_data_msb = ev_d1[7] ^ ev_d2[7];

  assign fifo_wdata = '{typ: ev_type, ch: ev_ch, d1: ev_d1[6:0], d2: ev_d2[6:0]};
  assign push_en    = ev_valid && !fifo_full && (ev_type != 3'd7);
  assign pop_en     = (state_q == LOAD);
  assign fire       = midi_out_ready && (guard_q == '0);

  midi_evt_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_AW    (FIFO_AW),
    .DATA_W     (EVT_W)
  ) u_fifo (
    .CLOCK_50    (CLOCK_50),
    .reset_reg_N (reset_reg_N),
    .push_i      (push_en),
    .wdata_i     (fifo_wdata),
    .pop_i       (pop_en),
    .rdata_o     (fifo_rdata),
    .level_o     (fifo_level),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Whether the FSM lands in IDLE after this edge. When it does the queue is
  // empty and nothing is popped, so busy next cycle depends only on a push.
  always_comb begin
    next_idle = 1'b0;
    case (state_q)
      IDLE:    next_idle = fifo_empty;
      D1:      next_idle = fire && (msg_len(cur_q.typ) == 2'd1) && fifo_empty;
      D2:      next_idle = fire && fifo_empty;
      default: next_idle = 1'b0;
    endcase
    busy_d = !next_idle || push_en;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q       <= IDLE;
      cur_q         <= '0;
      guard_q       <= '0;
      send_q        <= 1'b0;
      data_q        <= 8'h00;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
      last_status_q <= 8'h00;
`endif
    end else begin
      send_q <= 1'b0;
      err_q  <= ev_valid && !fifo_full && (ev_type == 3'd7);
      busy_q <= busy_d;
      if (guard_q != '0) guard_q <= guard_q - 1'b1;

      case (state_q)
        IDLE: begin
          if (!fifo_empty) state_q <= LOAD;
        end
        LOAD: begin
          cur_q <= fifo_rdata;
`ifdef MIDI_RUNNING_STATUS_EN
          state_q <= (status_byte(fifo_rdata) == last_status_q) ? D1 : STAT;
`else
          state_q <= STAT;
`endif
        end
        STAT: begin
          if (fire) begin
            send_q  <= 1'b1;
            data_q  <= status_byte(cur_q);
            guard_q <= GW'(GUARD_CYC);
            state_q <= D1;
`ifdef MIDI_RUNNING_STATUS_EN
            last_status_q <= status_byte(cur_q);
`endif
          end
        end
        D1: begin
          if (fire) begin
            send_q  <= 1'b1;
            data_q  <= {1'b0, cur_q.d1};
            guard_q <= GW'(GUARD_CYC);
            if (msg_len(cur_q.typ) == 2'd2) begin
              state_q <= D2;
            end else begin
              state_q <= fifo_empty ? IDLE : LOAD;
            end
          end
        end
        D2: begin
          if (fire) begin
            send_q  <= 1'b1;
            data_q  <= {1'b0, cur_q.d2};
            guard_q <= GW'(GUARD_CYC);
            state_q <= fifo_empty ? IDLE : LOAD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ev_ready       = !fifo_full;
  assign midi_send_byte = send_q;
  assign midi_out_data  = data_q;
  assign ev_err         = err_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_midi_msg_tx.sv
// tb_midi_msg_tx: directed and randomized bench for midi_msg_tx. Expected
// bytes come from a byte-queue model built from the message rules (status =
// 0x80 + 16*type + channel, data masked to 7 bits, 1 data byte for types 4/5).
module tb_midi_msg_tx;

  localparam int G = 2;

  logic       CLOCK_50 = 1'b0;
  logic       reset_reg_N = 1'b0;
  logic       ev_valid = 1'b0;
  logic [2:0] ev_type = '0;
  logic [3:0] ev_ch = '0;
  logic [7:0] ev_d1 = '0, ev_d2 = '0;
  logic       midi_out_ready = 1'b1;
  logic       ev_ready, midi_send_byte, ev_err, busy;
  logic [7:0] midi_out_data;
  logic [2:0] fifo_level;

  int tests = 0, fails = 0;
  int cyc = 0, nstrobe = 0, last_stamp = -100, acc_cyc = 0;
  int stamps[$];
  logic [7:0] exp_q[$];
  int  m_last = 0;
  bit  rdy_edge, rnd_ready = 0, acc;
  int  n0, lvl, ns;

  midi_msg_tx #(
    .FIFO_DEPTH (4),
    .FIFO_AW    (2),
    .GUARD_CYC  (G)
  ) dut (
    .CLOCK_50       (CLOCK_50),
    .reset_reg_N    (reset_reg_N),
    .ev_valid       (ev_valid),
    .ev_ready       (ev_ready),
    .ev_type        (ev_type),
    .ev_ch          (ev_ch),
    .ev_d1          (ev_d1),
    .ev_d2          (ev_d2),
    .midi_out_ready (midi_out_ready),
    .midi_send_byte (midi_send_byte),
    .midi_out_data  (midi_out_data),
    .ev_err         (ev_err),
    .busy           (busy),
    .fifo_level     (fifo_level)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Byte monitor: every strobe must match the head of the model queue.
  always @(posedge CLOCK_50) begin
    cyc++;
    rdy_edge = midi_out_ready;
    #1;
    if (midi_send_byte) begin
      nstrobe++;
      stamps.push_back(cyc);
      check_val("strobe_ready", rdy_edge, 1);
      check_val("strobe_gap", (cyc - last_stamp) >= G + 1, 1);
      last_stamp = cyc;
      check_val("strobe_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check_val("byte", midi_out_data, exp_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
      if (rnd_ready) midi_out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Offer one event for one cycle. use_model=0 means the caller already queued
  // literal expected bytes.
  task automatic send_evt(input int t, input int c, input int a, input int b,
                          input bit use_model, output bit accepted);
    int s;
    ev_type  = 3'(t);
    ev_ch    = 4'(c);
    ev_d1    = 8'(a);
    ev_d2    = 8'(b);
    ev_valid = 1'b1;
    accepted = ev_ready;
    @(posedge CLOCK_50);
    #1;
    ev_valid = 1'b0;
    if (accepted) begin
      acc_cyc = cyc;
      check_val("ev_err", ev_err, (t == 7));
      if (t != 7) begin
        s = 128 + 16 * t + c;
        if (use_model) begin
`ifdef MIDI_RUNNING_STATUS_EN
          if (s != m_last) exp_q.push_back(8'(s));
`else
          exp_q.push_back(8'(s));
`endif
          exp_q.push_back(8'(a & 127));
          if (!(t == 4 || t == 5)) exp_q.push_back(8'(b & 127));
        end
        m_last = s;
      end
    end
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      tick(1);
      k++;
    end
    check_val({tag, "_drain"}, exp_q.size(), 0);
    tick(G + 2);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_level"}, fifo_level, 0);
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_ev_ready"}, ev_ready, 1);
    check_val({tag, "_send"}, midi_send_byte, 0);
    check_val({tag, "_data"}, midi_out_data, 8'h00);
    check_val({tag, "_err"}, ev_err, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_level"}, fifo_level, 0);
  endtask

  initial begin
    @(posedge CLOCK_50);
    #1;
    check_reset("rst");
    reset_reg_N = 1'b1;
    tick(2);

    // Note on ch2: latency and exact strobe spacing.
    stamps.delete();
    exp_q.push_back(8'h92); exp_q.push_back(8'h3C); exp_q.push_back(8'h64);
    send_evt(1, 2, 8'h3C, 8'h64, 0, acc);
    check_val("non_acc", acc, 1);
    n0 = acc_cyc;
    drain("non");
    check_val("non_count", stamps.size(), 3);
    if (stamps.size() == 3) begin
      check_val("non_latency", stamps[0] - n0, 3);
      check_val("non_gap1", stamps[1] - stamps[0], G + 1);
      check_val("non_gap2", stamps[2] - stamps[1], G + 1);
    end

    // Program change: one data byte only.
    exp_q.push_back(8'hC0); exp_q.push_back(8'h05);
    send_evt(4, 0, 8'h05, 8'h7F, 0, acc);
    drain("prg");

    // Pitch bend: bit 7 of LSB masked.
    exp_q.push_back(8'hEF); exp_q.push_back(8'h7F); exp_q.push_back(8'h40);
    send_evt(6, 15, 8'hFF, 8'h40, 0, acc);
    drain("pitch");

    // Fill with the UART stalled: one event sits in the serializer, four queue.
    midi_out_ready = 1'b0;
    tick(2);
    for (int i = 0; i < 5; i++) begin
      send_evt($urandom_range(0, 6), i + 3, $urandom, $urandom, 1, acc);
      check_val("full_acc", acc, 1);
    end
    check_val("full_level", fifo_level, 4);
    check_val("full_ready", ev_ready, 0);
    send_evt(1, 9, 1, 2, 1, acc);
    check_val("full_reject", acc, 0);
    midi_out_ready = 1'b1;
    drain("full");

    // Illegal type: error pulse, nothing queued, nothing sent.
    lvl = fifo_level;
    ns  = nstrobe;
    send_evt(7, 3, 8'h11, 8'h22, 1, acc);
    check_val("ill_acc", acc, 1);
    tick(1);
    check_val("ill_err_off", ev_err, 0);
    check_val("ill_level", fifo_level, lvl);
    tick(10);
    check_val("ill_nobytes", nstrobe, ns);

    // Two note-ons on ch1.
    exp_q.push_back(8'h91); exp_q.push_back(8'h40); exp_q.push_back(8'h7F);
`ifndef MIDI_RUNNING_STATUS_EN
    exp_q.push_back(8'h91);
`endif
    exp_q.push_back(8'h43); exp_q.push_back(8'h7F);
    send_evt(1, 1, 8'h40, 8'h7F, 0, acc);
    send_evt(1, 1, 8'h43, 8'h7F, 0, acc);
    drain("rs");

    // Reset mid-message: stall after the first byte, then reset.
    ns = nstrobe;
    send_evt(1, 1, 8'h30, 8'h20, 1, acc);
    for (int k = 0; k < 50 && nstrobe == ns; k++) tick(1);
    check_val("mid_first", nstrobe, ns + 1);
    midi_out_ready = 1'b0;
    tick(3);
    reset_reg_N = 1'b0;
    exp_q.delete();
    m_last = 0;
    #1;
    check_reset("midrst");
    tick(1);
    reset_reg_N = 1'b1;
    midi_out_ready = 1'b1;
    ns = nstrobe;
    tick(20);
    check_val("mid_no_trail", nstrobe, ns);
    exp_q.push_back(8'h91); exp_q.push_back(8'h3C); exp_q.push_back(8'h50);
    send_evt(1, 1, 8'h3C, 8'h50, 0, acc);
    drain("post_rst");

    // Randomized traffic with a randomly stalling UART.
    rnd_ready = 1'b1;
    repeat (60) begin
      send_evt($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 255),
               $urandom_range(0, 255), 1, acc);
      tick($urandom_range(0, 3));
    end
    rnd_ready = 1'b0;
    midi_out_ready = 1'b1;
    drain("rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
